// File: rtl/bitlogic_pkg.sv
// Shared constants for the bitwise-logic pipeline: op encoding and field widths.
package bitlogic_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASSX = 3'd7;

endpackage

// File: rtl/bitlogic_stage.sv
// One pipeline register slice: valid bit plus data word, loaded on enable,
// cleared asynchronously. Data only captures when a valid beat is loaded.
module bitlogic_stage #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          valid_d,
  input  logic [DW-1:0] data_d,
  output logic          valid_q,
  output logic [DW-1:0] data_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= valid_d;
      if (valid_d) begin
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/bitlogic_pipe.sv
// Two-stage valid/ready pipeline applying a per-bit logic op to x and y.
// Define BITLOGIC_FLAGS_EN to compute {parity, all_ones, zero} flags into S2.
module bitlogic_pipe
  import bitlogic_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned HOLD_OUT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic [FLAG_W-1:0] flags
);

`ifdef BITLOGIC_FLAGS_EN
  localparam int unsigned S2_W = WIDTH + FLAG_W;
`else
  localparam int unsigned S2_W = WIDTH;
`endif

  logic [WIDTH-1:0] res_c;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s2_valid;
  logic [S2_W-1:0]  s2_data;
  logic [S2_W-1:0]  s2_din_c;
  logic             s2_load;
  logic             s1_advance;
  logic             s1_load;

  // Per-bit operation; no carries between bit positions.
  always_comb begin
    res_c = '0;
    case (op)
      OP_AND:   res_c = x & y;
      OP_OR:    res_c = x | y;
      OP_XOR:   res_c = x ^ y;
      OP_XNOR:  res_c = ~(x ^ y);
      OP_NAND:  res_c = ~(x & y);
      OP_NOR:   res_c = ~(x | y);
      OP_ANDN:  res_c = x & ~y;
      OP_PASSX: res_c = x;
      default:  res_c = '0;
    endcase
  end

  // Handshake: in_ready is a function of stage state and out_ready only.
  assign s2_load    = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign s1_load    = !s1_valid || s1_advance;
  assign in_ready   = rst_n && s1_load;

`ifdef BITLOGIC_FLAGS_EN
  assign s2_din_c = {^s1_data, &s1_data, ~|s1_data, s1_data};
`else
  assign s2_din_c = s1_data;
`endif

  bitlogic_stage #(.DW(WIDTH)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (s1_load),
    .valid_d (in_valid),
    .data_d  (res_c),
    .valid_q (s1_valid),
    .data_q  (s1_data)
  );

  bitlogic_stage #(.DW(S2_W)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (s2_load),
    .valid_d (s1_valid),
    .data_d  (s2_din_c),
    .valid_q (s2_valid),
    .data_q  (s2_data)
  );

  assign out_valid = s2_valid;

  // S2 only loads when empty or consumed, so out is stable under backpressure
  // in both modes; there is no bypass path for HOLD_OUT=0 to select.
  if (HOLD_OUT != 0) begin : g_hold
    assign out = s2_data[WIDTH-1:0];
  end else begin : g_nohold
    assign out = s2_data[WIDTH-1:0];
  end

`ifdef BITLOGIC_FLAGS_EN
  assign flags = s2_data[S2_W-1 -: FLAG_W];
`else
  assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_bitlogic_pipe.sv
// Scoreboard bench for bitlogic_pipe: truth-table reference model, randomized
// backpressure, directed latency/stall/reset scenarios.
module tb_bitlogic_pipe;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [2:0]   flags;

  bitlogic_pipe #(.WIDTH(W), .HOLD_OUT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   flg;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_stall = -1;
  logic rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Each op is a 4-entry truth table indexed by {x_bit, y_bit}.
  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (o)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b1001;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < int'(W); i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [W-1:0] d);
    logic [2:0] f;
    f = {($countones(d) % 2) == 1, $countones(d) == int'(W), $countones(d) == 0};
`ifndef BITLOGIC_FLAGS_EN
    f = 3'b000;
`endif
    return f;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Acceptor: records the expected result of every beat that will transfer.
  always @(negedge clk) begin : acceptor
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      e.data = ref_op(op, x, y);
      e.flg  = ref_flags(e.data);
      e.acc  = cyc;
      sb.push_back(e);
    end
  end

  // Monitor: pops and compares on every output transfer, checks hold under stall.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out;
  logic [2:0]   prev_flg;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_out", 64'(out), 64'(prev_out));
        check("hold_flags", 64'(flags), 64'(prev_flg));
      end
      if (!out_ready) last_stall = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_beat: actual out=%0h required no beat", out);
        end else begin
          e = sb.pop_front();
          check("out", 64'(out), 64'(e.data));
          check("flags", 64'(flags), 64'(e.flg));
          if (last_stall < e.acc) check("latency", 64'(cyc - e.acc), 64'(2));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      prev_flg   = flags;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called just after a rising edge; returns just after the edge of transfer.
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    op = o;
    x = a;
    y = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: actual in_ready=0 required 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (sb.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL drain_timeout: actual pending=%0d required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual time=%0t required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 3'd0;
    x = '0;
    y = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_low", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out", 64'(out), 64'(0));
    check("rst_flags", 64'(flags), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // XNOR example, then zero / all-ones flag cases.
    out_ready = 1'b1;
    send(3'd3, 32'hFFFF0000, 32'h0F0F0F0F);
    send(3'd2, 32'h12345678, 32'h12345678);
    send(3'd5, 32'h00000000, 32'h00000000);
    send(3'd6, 32'hFFFFFFFF, 32'h00000000);
    drain();

    // Back-to-back stream of all eight ops.
    for (int i = 0; i < 8; i++) send(3'(i), 32'hA5A5A5A5, 32'h3C3C3C3C);
    drain();

    // Backpressure: two beats fill the pipe, the third waits.
    out_ready = 1'b0;
    send(3'd0, 32'h11111111, 32'h0F0F0F0F);
    send(3'd1, 32'h22222222, 32'h0F0F0F0F);
    fork
      begin
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_out_valid", 64'(out_valid), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    send(3'd2, 32'h33333333, 32'h0F0F0F0F);
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(3'd0, W'($urandom), W'($urandom));
    send(3'd1, W'($urandom), W'($urandom));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out", 64'(out), 64'(0));
    check("midrst_flags", 64'(flags), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("relrst_out_valid", 64'(out_valid), 64'(0));
    check("relrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    send(3'd2, W'($urandom), W'($urandom));
    drain();

    // Randomized traffic with random backpressure and idle gaps.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = '1;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send(3'($urandom_range(0, 7)), a, b);
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
